// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the 4-digit scanned 7-segment driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_FLASH
    } flash_state_t;

    function automatic logic is_player(input logic [2:0] p);
        return (p == 3'b100) || (p == 3'b010) || (p == 3'b001);
    endfunction

    function automatic logic [6:0] player_seg(input logic [2:0] p);
        logic [6:0] r;
        case (p)
            3'b100:  r = SEG_A;
            3'b010:  r = SEG_B;
            3'b001:  r = SEG_C;
            3'b000:  r = SEG_BLANK;
            default: r = SEG_DASH;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// BCD digit to active-low 7-segment pattern, with optional zero blanking.
// Non-BCD codes render as a dash so bad upstream data is visible.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank_zero,
    output logic [6:0] pattern
);

    // Pure lookup; zero blanking is used for leading-zero suppression.
    always_comb begin
        pattern = SEG_DASH;
        case (digit)
            4'd0:    pattern = blank_zero ? SEG_BLANK : SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with frame-buffered
// inputs and a flashing player letter after a buzzer change.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 64,
    parameter int FLASH_HALF   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [2:0] thousands,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    logic [PW-1:0] presc;
    logic [1:0]    slot;
    logic          tick;
    logic          boundary;

    logic [3:0]    ones_q;
    logic [3:0]    tens_q;
    logic [2:0]    player_q;
    logic          primed;

    flash_state_t  state;
    logic [FW-1:0] frame_cnt;
    logic          flash_off;

    logic [6:0]    ones_seg;
    logic [6:0]    tens_seg;
    logic [6:0]    slot_seg;

    assign tick     = (presc == PW'(REFRESH_DIV - 1));
    assign boundary = tick && (slot == 2'd3);
    assign dp       = 1'b1;

    // Free-running slot timer: one slot every REFRESH_DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            slot  <= 2'd0;
        end else if (tick) begin
            presc <= '0;
            slot  <= slot + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Frame buffer plus player-flash FSM, both updated only at frame edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q    <= '0;
            tens_q    <= '0;
            player_q  <= '0;
            primed    <= 1'b0;
            state     <= ST_IDLE;
            frame_cnt <= '0;
        end else if (boundary) begin
            ones_q   <= ones;
            tens_q   <= tens;
            player_q <= thousands;
            primed   <= 1'b1;
            if (is_player(thousands) && (thousands != player_q)) begin
                state     <= ST_FLASH;
                frame_cnt <= '0;
            end else begin
                case (state)
                    ST_FLASH: begin
                        if ((frame_cnt == FW'(FLASH_FRAMES - 1)) ||
                            !is_player(thousands)) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign flash_off = (state == ST_FLASH) &&
                       (((32'(frame_cnt) / FLASH_HALF) % 2) == 1);

    sevenseg_decode u_ones (
        .digit      (ones_q),
        .blank_zero (1'b0),
        .pattern    (ones_seg)
    );

    sevenseg_decode u_tens (
        .digit      (tens_q),
        .blank_zero (1'b1),
        .pattern    (tens_seg)
    );

    // Pattern for the digit currently being scanned.
    always_comb begin
        slot_seg = SEG_BLANK;
        case (slot)
            2'd0:    slot_seg = ones_seg;
            2'd1:    slot_seg = tens_seg;
            2'd2:    slot_seg = SEG_BLANK;
            default: slot_seg = flash_off ? SEG_BLANK : player_seg(player_q);
        endcase
    end

    // Registered pins; one dark clock at every slot change kills ghosting.
    always_ff @(posedge clk) begin
        if (rst || tick || !primed) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << slot);
            seg <= slot_seg;
        end
    end

endmodule
